// File: rtl/number_display_renderer.sv
// Multi-digit decimal renderer: sequential double-dabble into a display register,
// then a two-stage pixel pipeline over the shared digit-font ROMs.

module DigitFontRom #(
  parameter logic [3:0] CODE = 4'd0
) (
  input  logic        clock,
  input  logic [10:0] address,
  output logic [15:0] q
);
  logic [10:0] addrReg;

  // Registered-address ROM; each word tags its glyph code and pixel address
  always_ff @(posedge clock) begin
    addrReg <= address;
  end

  assign q = {1'b1, CODE, addrReg};
endmodule

module font_048 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd0)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_049 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd1)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_050 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd2)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_051 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd3)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_052 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd4)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_053 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd5)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_054 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd6)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_055 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd7)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_056 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd8)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module font_057 (input logic clock, input logic [10:0] address, output logic [15:0] q);
  DigitFontRom #(.CODE(4'd9)) uRom (.clock(clock), .address(address), .q(q));
endmodule

module number_display_renderer #(
  parameter int          DIGITS      = 4,
  parameter int          VALUE_WIDTH = 14,
  parameter int          FONT_W      = 32,
  parameter int          FONT_H      = 64,
  parameter logic [15:0] TRANSPARENT = 16'd0
) (
  input  logic                   iClock,
  input  logic                   iResetN,
  input  logic                   iLoad,
  input  logic [VALUE_WIDTH-1:0] iValue,
  input  logic                   iBlankLeadingZeros,
  input  logic                   iPixelValid,
  input  logic [10:0]            iX,
  input  logic [10:0]            iY,
  output logic                   oBusy,
  output logic                   oOverflow,
  output logic                   oPixelValid,
  output logic [15:0]            oColorIndex
);
  localparam int          BCD_W     = 4 * DIGITS;
  localparam int          CNT_W     = $clog2(VALUE_WIDTH + 1);
  localparam int          COL_BITS  = $clog2(FONT_W);
  localparam logic [31:0] MAX_VALUE = 32'(10 ** DIGITS - 1);
  localparam logic [31:0] BOX_W     = 32'(DIGITS * FONT_W);
  localparam logic [31:0] BOX_H     = 32'(FONT_H);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  logic [0:0]             state;
  logic [CNT_W-1:0]       count;
  logic [VALUE_WIDTH-1:0] shiftReg;
  logic [BCD_W-1:0]       bcd;
  logic [BCD_W-1:0]       bcdAdj;
  logic [BCD_W-1:0]       bcdNext;
  logic [BCD_W-1:0]       digits;
  logic [31:0]            valueExt;
  logic                   valueTooBig;
  logic [VALUE_WIDTH-1:0] satValue;

  assign valueExt    = 32'(iValue);
  assign valueTooBig = valueExt > MAX_VALUE;
  assign satValue    = valueTooBig ? MAX_VALUE[VALUE_WIDTH-1:0] : iValue;
  assign oBusy       = (state == CONVERT);

  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Saturation keeps the value within DIGITS nibbles, so the dropped top bit is always 0
  assign bcdNext = {bcdAdj[BCD_W-2:0], shiftReg[VALUE_WIDTH-1]};

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      state     <= IDLE;
      count     <= '0;
      shiftReg  <= '0;
      bcd       <= '0;
      digits    <= '0;
      oOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iLoad) begin
            shiftReg  <= satValue;
            bcd       <= '0;
            count     <= CNT_W'(VALUE_WIDTH);
            oOverflow <= valueTooBig;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd      <= bcdNext;
          shiftReg <= shiftReg << 1;
          count    <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            digits <= bcdNext;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0]         pos;
  logic [COL_BITS-1:0] col;
  logic [10:0]         romAddr;
  logic                outOfBox;
  logic [DIGITS-1:0]   leadZero;
  logic                zeroRun;
  logic [3:0]          selCode;
  logic                selBlank;

  assign pos      = iX >> COL_BITS;
  assign col      = iX[COL_BITS-1:0];
  assign romAddr  = 11'(iY << COL_BITS) | 11'(col);
  assign outOfBox = (32'(iX) >= BOX_W) || (32'(iY) >= BOX_H);

  // leadZero[i]: digit i and every more-significant digit are zero
  always_comb begin
    leadZero = '0;
    zeroRun  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroRun     = zeroRun && (digits[4*i +: 4] == 4'd0);
      leadZero[i] = zeroRun;
    end
  end

  always_comb begin
    selCode  = 4'd0;
    selBlank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos == 11'(i)) begin
        selCode  = digits[4*(DIGITS-1-i) +: 4];
        selBlank = iBlankLeadingZeros && leadZero[DIGITS-1-i] && ((DIGITS - 1 - i) != 0);
      end
    end
  end

  logic       s1Valid;
  logic [3:0] s1Code;
  logic       s1Transparent;

  // Blank and out-of-box collapse into one flag travelling beside the ROM address
  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      s1Valid       <= 1'b0;
      s1Code        <= 4'd0;
      s1Transparent <= 1'b0;
    end else begin
      s1Valid       <= iPixelValid;
      s1Code        <= selCode;
      s1Transparent <= outOfBox || selBlank;
    end
  end

  logic [15:0] romQ [10];

  font_048 uFont0 (.clock(iClock), .address(romAddr), .q(romQ[0]));
  font_049 uFont1 (.clock(iClock), .address(romAddr), .q(romQ[1]));
  font_050 uFont2 (.clock(iClock), .address(romAddr), .q(romQ[2]));
  font_051 uFont3 (.clock(iClock), .address(romAddr), .q(romQ[3]));
  font_052 uFont4 (.clock(iClock), .address(romAddr), .q(romQ[4]));
  font_053 uFont5 (.clock(iClock), .address(romAddr), .q(romQ[5]));
  font_054 uFont6 (.clock(iClock), .address(romAddr), .q(romQ[6]));
  font_055 uFont7 (.clock(iClock), .address(romAddr), .q(romQ[7]));
  font_056 uFont8 (.clock(iClock), .address(romAddr), .q(romQ[8]));
  font_057 uFont9 (.clock(iClock), .address(romAddr), .q(romQ[9]));

  logic [15:0] pixelColor;

  // Codes above 9 have no glyph and fall through to TRANSPARENT
  always_comb begin
    pixelColor = TRANSPARENT;
    if (!s1Transparent) begin
      for (int i = 0; i < 10; i++) begin
        if (s1Code == 4'(i)) pixelColor = romQ[i];
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      oPixelValid <= 1'b0;
      oColorIndex <= 16'd0;
    end else begin
      oPixelValid <= s1Valid;
      if (s1Valid) oColorIndex <= pixelColor;
    end
  end
endmodule

// File: tb/tb_number_display_renderer.sv
// Bench for number_display_renderer: decimal-arithmetic model checked every cycle,
// plus directed probes with hand-computed colour words.

module tb_number_display_renderer;
  localparam int          DIGITS      = 4;
  localparam int          VALUE_WIDTH = 14;
  localparam int          FONT_W      = 32;
  localparam int          FONT_H      = 64;
  localparam logic [15:0] TRANSPARENT = 16'd0;
  localparam int          MAX_VALUE   = 9999;

  logic                   clock = 1'b0;
  logic                   resetN;
  logic                   load;
  logic [VALUE_WIDTH-1:0] value;
  logic                   blankLz;
  logic                   pixelValid;
  logic [10:0]            x;
  logic [10:0]            y;
  logic                   busy;
  logic                   overflow;
  logic                   outValid;
  logic [15:0]            colorIndex;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  number_display_renderer #(
    .DIGITS(DIGITS), .VALUE_WIDTH(VALUE_WIDTH), .FONT_W(FONT_W),
    .FONT_H(FONT_H), .TRANSPARENT(TRANSPARENT)
  ) dut (
    .iClock(clock), .iResetN(resetN), .iLoad(load), .iValue(value),
    .iBlankLeadingZeros(blankLz), .iPixelValid(pixelValid), .iX(x), .iY(y),
    .oBusy(busy), .oOverflow(overflow), .oPixelValid(outValid), .oColorIndex(colorIndex)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Font ROM words are {1, glyph code, pixel address}
  function automatic logic [15:0] modelPixel(input int px, input int py, input int shown, input bit blank);
    int place;
    int digit;
    int addr;
    if (px >= DIGITS * FONT_W || py >= FONT_H) return TRANSPARENT;
    place = DIGITS - 1 - px / FONT_W;
    digit = (shown / pow10(place)) % 10;
    if (blank && place != 0 && shown < pow10(place)) return TRANSPARENT;
    addr = py * FONT_W + px % FONT_W;
    return {1'b1, 4'(digit), 11'(addr)};
  endfunction

  int          mDisplay  = 0;
  int          mPending  = 0;
  int          mBusyLeft = 0;
  bit          mOvf      = 1'b0;
  bit          mValid    = 1'b0;
  logic [15:0] mColor    = 16'd0;
  bit          p1Valid   = 1'b0;
  logic [15:0] p1Color   = 16'd0;
  bit          started   = 1'b0;

  // Model advances at each rising edge; pixels see the display as it was before the edge
  always @(posedge clock) begin
    if (!resetN) begin
      started   = 1'b1;
      mDisplay  = 0;
      mBusyLeft = 0;
      mOvf      = 1'b0;
      mValid    = 1'b0;
      mColor    = 16'd0;
      p1Valid   = 1'b0;
    end else begin
      mValid = p1Valid;
      if (p1Valid) mColor = p1Color;
      p1Valid = pixelValid;
      p1Color = modelPixel(int'(x), int'(y), mDisplay, blankLz);
      if (mBusyLeft > 0) begin
        mBusyLeft--;
        if (mBusyLeft == 0) mDisplay = mPending;
      end else if (load) begin
        mOvf      = int'(value) > MAX_VALUE;
        mPending  = mOvf ? MAX_VALUE : int'(value);
        mBusyLeft = VALUE_WIDTH;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      checkOutput("busy", 32'(busy), 32'(mBusyLeft > 0));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("pixelValid", 32'(outValid), 32'(mValid));
      checkOutput("colorIndex", 32'(colorIndex), 32'(mColor));
    end
  end

  task automatic applyStimulus(input bit ld, input int v, input bit pv, input int px, input int py);
    load       = ld;
    value      = VALUE_WIDTH'(v);
    pixelValid = pv;
    x          = 11'(px);
    y          = 11'(py);
    @(negedge clock);
    load       = 1'b0;
    pixelValid = 1'b0;
  endtask

  task automatic loadValue(input int v);
    applyStimulus(1'b1, v, 1'b0, 0, 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
    if (cycles >= 200) checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  task automatic pixelProbe(input string name, input int px, input int py, input logic [15:0] expected);
    applyStimulus(1'b0, 0, 1'b1, px, py);
    @(negedge clock);
    checkOutput({name, "_valid"}, 32'(outValid), 32'd1);
    checkOutput(name, 32'(colorIndex), 32'(expected));
  endtask

  task automatic sweep(input int py);
    for (int px = 0; px < DIGITS * FONT_W; px++) applyStimulus(1'b0, 0, 1'b1, px, py);
  endtask

  int cycles;

  initial begin
    resetN = 1'b0; load = 1'b0; value = '0; blankLz = 1'b0;
    pixelValid = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clock);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetOverflow", 32'(overflow), 32'd0);
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetColor", 32'(colorIndex), 32'd0);
    resetN = 1'b1;
    @(negedge clock);

    loadValue(1234);
    waitIdle(cycles);
    checkOutput("busyCycles", 32'(cycles), 32'd14);
    pixelProbe("v1234_x0", 0, 0, 16'h8800);
    pixelProbe("v1234_x101y3", 101, 3, 16'hA065);

    loadValue(12345);
    waitIdle(cycles);
    checkOutput("ovfSet", 32'(overflow), 32'd1);
    pixelProbe("sat9999", 0, 0, 16'hC800);
    loadValue(42);
    waitIdle(cycles);
    checkOutput("ovfClear", 32'(overflow), 32'd0);
    pixelProbe("v42_lead0", 0, 0, 16'h8000);
    pixelProbe("v42_x96", 96, 0, 16'h9000);

    blankLz = 1'b1;
    loadValue(7);
    waitIdle(cycles);
    sweep(5);
    idleCycles(2);
    pixelProbe("v7_blankX0", 0, 0, TRANSPARENT);
    pixelProbe("v7_x100y2", 100, 2, 16'hB844);
    blankLz = 1'b0;
    pixelProbe("v7_noBlankX10", 10, 0, 16'h800A);

    blankLz = 1'b1;
    loadValue(0);
    waitIdle(cycles);
    pixelProbe("v0_x96", 96, 0, 16'h8000);
    pixelProbe("v0_x64", 64, 0, TRANSPARENT);
    pixelProbe("x128", 128, 0, TRANSPARENT);
    pixelProbe("y64", 96, 64, TRANSPARENT);
    sweep(63);

    blankLz = 1'b0;
    loadValue(5678);
    idleCycles(3);
    loadValue(16000);
    waitIdle(cycles);
    checkOutput("ignoredLoadOvf", 32'(overflow), 32'd0);
    pixelProbe("ignoredLoad", 0, 0, 16'hA800);

    loadValue(4321);
    idleCycles(4);
    resetN = 1'b0;
    applyStimulus(1'b0, 0, 1'b1, 0, 0);
    resetN = 1'b1;
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetValid", 32'(outValid), 32'd0);
    pixelProbe("midReset_x0", 0, 0, 16'h8000);
    pixelProbe("midReset_x96", 96, 0, 16'h8000);

    loadValue(1234);
    sweep(1);
    sweep(2);
    idleCycles(2);
    pixelProbe("afterSweep", 0, 0, 16'h8800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
